crc_serial_engine: RTL and testbench
====================================

# crc_serial_engine

Parametrised serial CRC engine; next generation of the team's fixed 8-bit serial CRC generator. Accepts a bit-serial frame of any length and then runs in one of two modes. In generate mode it streams the WIDTH-bit CRC out LSB-first. In check mode it verifies a frame that already carries its CRC. It sits between the bit-serial framer and the line encoder; a per-frame `done` pulse reports completion to the link controller.

## Interface
- `WIDTH`, 8: CRC register width (≥2).
- `POLY`, 7'h44: reflected tap mask, WIDTH-1 bits; bit i set ⇒ XOR feedback into stage i.
- `INIT`, 8'hD8: CRC register value at reset and at the start of every frame.
- `CNT_W`, 16: frame bit-counter width.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `active` in 1: frame bit strobe; `data` is sampled on each rising edge while high.
- `data` in 1: serial frame bit.
- `mode` in 1: 0 = generate, 1 = check; latched on the first bit of a frame.
- `crc_out` out 1: serial CRC bit (generate mode).
- `valid` out 1: `crc_out` is meaningful.
- `busy` out 1: engine is in OUT or CHECK; `active` is ignored.
- `done` out 1: one-cycle end-of-frame pulse.
- `crc_ok` out 1: check result, held until the next `done`.
- `err` out 1: length error, held until the next `done`.

## Operation
- LFSR `crc_q[WIDTH-1:0]` uses Galois right-shift.
  - `fb = crc_q[0] ^ data`.
  - `next[WIDTH-1] = fb`.
  - `next[i] = crc_q[i+1] ^ (POLY[i] & fb)`.
- FSM has states IDLE, SHIFT, OUT, CHECK. Reset state is IDLE.
- IDLE:
  - `active`=1: shift in `data`, latch `mode`, set `len` to 1, go to SHIFT.
  - Otherwise hold.
- SHIFT:
  - `active`=1: shift, `len`+1. `len` saturates at all-ones and sets an internal overflow flag.
  - `active`=0: end of frame. Latched mode 0 → OUT; mode 1 → CHECK. Gaps in `active` therefore terminate the frame.
- OUT, WIDTH cycles, driven by the output counter `oc`:
  - Each edge registers `crc_out <= crc_q[0]` and `valid <= 1`.
  - Each edge shifts `crc_q` right with 0 fill.
  - On the edge after the last bit: `valid <= 0`, `done <= 1`, `crc_q <= INIT`, `err <= overflow`, go to IDLE.
- CHECK, one cycle:
  - `crc_ok <= (crc_q == 0) && (len ≥ WIDTH+1) && !overflow`.
  - `err <= (len < WIDTH+1) || overflow`.
  - `done <= 1`, `crc_q <= INIT`, go to IDLE.
- `busy` = state ∈ {OUT, CHECK}. `active` during busy is dropped with no effect. Upstream must hold off while `busy`=1.
- In generate mode `crc_ok` is forced to 0 at `done`.

## Timing
- Reset values:
  - `crc_q` = INIT.
  - `crc_out`, `valid`, `busy`, `done`, `crc_ok`, `err` = 0.
  - State IDLE; `len`, `oc` = 0.
- Reset asserted mid-frame or mid-OUT: all of the above apply immediately (asynchronous). The partial frame is discarded.
- Generate latency: first clock edge with `active`=0 after the last bit registers CRC bit 0.
  - `valid` is then high for exactly WIDTH consecutive cycles.
  - `done` rises in the cycle after the last `valid`.
- Check latency: `done`, `crc_ok` and `err` are registered on the second edge after the last frame bit, i.e. the edge leaving CHECK.
- Back-to-back frames: `active`=1 in the cycle after `done` is accepted (IDLE). `active` held high through OUT/CHECK is ignored until IDLE is reached, then starts a new frame.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Default parameters, generate mode, frame "1":
  - Register holds 0xA8 after the bit.
  - `crc_out` = 0,0,0,1,0,1,0,1 over 8 cycles with `valid` high.
  - Then `done` pulses, `err`=0, and `crc_q` returns to 0xD8.
- Generate mode, frame "0": register holds 0x6C; `crc_out` = 0,0,1,1,0,1,1,0.
- Check mode, frame "1" followed by 0,0,0,1,0,1,0,1 (9 bits): `crc_ok`=1, `err`=0. Flip any one bit → `crc_ok`=0.
- Check mode, 5-bit frame: `done`, `err`=1, `crc_ok`=0.
- Reset mid-OUT at bit 3: `valid`, `crc_out` and `busy` drop to 0 immediately; `crc_q`=0xD8. The next frame "1" again yields 0xA8.
- `active` held high through OUT and reasserted in the cycle after `done`:
  - Bits during `busy` are ignored.
  - The new frame starts from INIT.
- WIDTH=16, POLY=15'h4001, INIT=16'hFFFF: generate then check the same random 64-bit frame → `crc_ok`=1.

Source files
------------

// File: rtl/crc_serial_engine.sv
`default_nettype none
// ============================================================================
// crc_serial_engine : bit-serial Galois CRC, generate (LSB-first out) or check
// Revision 1.0
// ============================================================================
module crc_serial_engine #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-2:0] POLY  = 7'h44,
    parameter logic [WIDTH-1:0] INIT  = 8'hD8,
    parameter int               CNT_W = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic data,
    input  logic mode,
    output logic crc_out,
    output logic valid,
    output logic busy,
    output logic done,
    output logic crc_ok,
    output logic err
);

    localparam int               OC_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(WIDTH + 1);
    localparam logic [OC_W-1:0]  OC_LAST = OC_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_OUT   = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  crc_q, crc_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [OC_W-1:0]   oc_q, oc_d;
    logic              mode_q, mode_d;
    logic              ovf_q, ovf_d;
    logic              crc_out_q, crc_out_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              crc_ok_q, crc_ok_d;
    logic              err_q, err_d;

    logic              fb;
    logic [WIDTH-1:0]  crc_step;
    logic [WIDTH-1:0]  crc_drain;

    always_comb begin
        fb        = crc_q[0] ^ data;
        crc_step  = {fb, crc_q[WIDTH-1:1] ^ (POLY & {(WIDTH-1){fb}})};
        crc_drain = {1'b0, crc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        len_d     = len_q;
        oc_d      = oc_q;
        mode_d    = mode_q;
        ovf_d     = ovf_q;
        crc_out_d = 1'b0;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        crc_ok_d  = crc_ok_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (active) begin
                    crc_d   = crc_step;
                    mode_d  = mode;
                    len_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (active) begin
                    crc_d = crc_step;
                    if (len_q == '1) begin
                        ovf_d = 1'b1;
                    end else begin
                        len_d = len_q + CNT_W'(1);
                    end
                end else if (mode_q) begin
                    state_d = S_CHECK;
                end else begin
                    // The frame-end edge already emits CRC bit 0.
                    crc_out_d = crc_q[0];
                    valid_d   = 1'b1;
                    crc_d     = crc_drain;
                    oc_d      = OC_W'(1);
                    state_d   = S_OUT;
                end
            end
            S_OUT: begin
                if (oc_q == OC_LAST) begin
                    done_d   = 1'b1;
                    crc_d    = INIT;
                    err_d    = ovf_q;
                    crc_ok_d = 1'b0;
                    oc_d     = '0;
                    state_d  = S_IDLE;
                end else begin
                    crc_out_d = crc_q[0];
                    valid_d   = 1'b1;
                    crc_d     = crc_drain;
                    oc_d      = oc_q + OC_W'(1);
                end
            end
            S_CHECK: begin
                crc_ok_d = (crc_q == '0) && (len_q >= MIN_LEN) && !ovf_q;
                err_d    = (len_q < MIN_LEN) || ovf_q;
                done_d   = 1'b1;
                crc_d    = INIT;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_OUT) || (state_d == S_CHECK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            crc_q     <= INIT;
            len_q     <= '0;
            oc_q      <= '0;
            mode_q    <= 1'b0;
            ovf_q     <= 1'b0;
            crc_out_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            crc_ok_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            len_q     <= len_d;
            oc_q      <= oc_d;
            mode_q    <= mode_d;
            ovf_q     <= ovf_d;
            crc_out_q <= crc_out_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            crc_ok_q  <= crc_ok_d;
            err_q     <= err_d;
        end
    end

    assign crc_out = crc_out_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign crc_ok  = crc_ok_q;
    assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_crc_serial_engine.sv
`default_nettype none
// ============================================================================
// tb_crc_serial_engine : randomized frames against a frame-level CRC model
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_crc_serial_engine;

    localparam int W = 8;
    localparam int N = 8192;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic active = 1'b0, data = 1'b0, mode = 1'b0;
    logic crc_out, valid, busy, done, crc_ok, err;
    logic active2 = 1'b0, data2 = 1'b0, mode2 = 1'b0;
    logic crc_out2, valid2, busy2, done2, crc_ok2, err2;

    crc_serial_engine dut (
        .clk(clk), .reset(reset), .active(active), .data(data), .mode(mode),
        .crc_out(crc_out), .valid(valid), .busy(busy), .done(done),
        .crc_ok(crc_ok), .err(err)
    );

    crc_serial_engine #(.WIDTH(16), .POLY(15'h4001), .INIT(16'hFFFF), .CNT_W(16)) dut2 (
        .clk(clk), .reset(reset), .active(active2), .data(data2), .mode(mode2),
        .crc_out(crc_out2), .valid(valid2), .busy(busy2), .done(done2),
        .crc_ok(crc_ok2), .err(err2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Frame-level CRC: feed each bit through the reflected polynomial.
    function automatic logic [15:0] model_crc(input logic [15:0] init, input logic [15:0] poly,
                                              input int w, input int n, input logic [127:0] bits);
        logic [15:0] r;
        logic        f;
        r = init;
        for (int j = 0; j < n; j++) begin
            f = r[0] ^ bits[j];
            r = r >> 1;
            if (f) r = r ^ poly ^ (16'(1) << (w - 1));
        end
        return r;
    endfunction

    // Expected outputs, indexed by the posedge count that produced them.
    bit exp_valid [N];
    bit exp_bit   [N];
    bit exp_busy  [N];
    bit exp_done  [N];
    bit exp_ok    [N];
    bit exp_err   [N];
    bit chk_en = 1'b0;
    bit h_ok = 1'b0, h_err = 1'b0;
    int k_c;

    always @(negedge clk) begin
        if (chk_en) begin
            k_c = cyc;
            if (exp_done[k_c]) begin
                h_ok  = exp_ok[k_c];
                h_err = exp_err[k_c];
            end
            chk("valid",  32'(valid),  32'(exp_valid[k_c]));
            chk("busy",   32'(busy),   32'(exp_busy[k_c]));
            chk("done",   32'(done),   32'(exp_done[k_c]));
            chk("crc_ok", 32'(crc_ok), 32'(h_ok));
            chk("err",    32'(err),    32'(h_err));
            if (exp_valid[k_c]) chk("crc_out", 32'(crc_out), 32'(exp_bit[k_c]));
        end
    end

    task automatic clear_from(input int first);
        for (int i = first; i < N; i++) begin
            exp_valid[i] = 0; exp_bit[i] = 0; exp_busy[i] = 0;
            exp_done[i] = 0;  exp_ok[i] = 0;  exp_err[i] = 0;
        end
    endtask

    // Drives one frame from a negedge, with junk on active while busy, and
    // returns at the negedge following the done edge.
    task automatic send_frame(input bit m, input int n, input logic [127:0] bits);
        int          s;
        logic [15:0] c;
        s = cyc + 1;
        if (s + n + W + 2 >= N) begin
            failures++;
            $display("FAIL cycle_budget at cycle %0d: got %0d expected below %0d", cyc, s + n + W + 2, N);
            return;
        end
        c = model_crc(16'h00D8, 16'h0044, W, n, bits);
        if (!m) begin
            for (int k = 0; k < W; k++) begin
                exp_valid[s+n+k] = 1;
                exp_bit[s+n+k]   = c[k];
                exp_busy[s+n+k]  = 1;
            end
            exp_done[s+n+W] = 1;
            exp_ok[s+n+W]   = 0;
            exp_err[s+n+W]  = 0;
        end else begin
            exp_busy[s+n]   = 1;
            exp_done[s+n+1] = 1;
            exp_ok[s+n+1]   = (c[W-1:0] == '0) && (n >= W + 1);
            exp_err[s+n+1]  = (n < W + 1);
        end
        for (int j = 0; j < n; j++) begin
            mode   = (j == 0) ? m : 1'($urandom);
            active = 1'b1;
            data   = bits[j];
            @(negedge clk);
        end
        active = 1'b0;
        data   = 1'($urandom);
        @(negedge clk);
        repeat (m ? 1 : W) begin
            active = 1'($urandom);
            data   = 1'($urandom);
            @(negedge clk);
        end
        active = 1'b0;
    endtask

    logic [127:0] fr;
    logic [15:0]  cc, cap, c2;
    int           n, nb, tmo;
    bit           m;

    initial begin
        clear_from(0);
        chk("model_frame_1", 32'(model_crc(16'h00D8, 16'h0044, W, 1, 128'h1)), 32'h00A8);
        chk("model_frame_0", 32'(model_crc(16'h00D8, 16'h0044, W, 1, 128'h0)), 32'h006C);
        chk("model_check_9", 32'(model_crc(16'h00D8, 16'h0044, W, 9, 128'h151)), 32'h0000);

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_crc_ok", 32'(crc_ok), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_crc_out", 32'(crc_out), 0);
        chk("rst_crc_q", 32'(dut.crc_q), 32'hD8);
        reset  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        fork
            send_frame(1'b0, 1, 128'h1);
            begin @(negedge clk); chk("crc_q_after_1", 32'(dut.crc_q), 32'hA8); end
        join
        chk("crc_q_init_after_done", 32'(dut.crc_q), 32'hD8);
        chk("gen_err", 32'(err), 0);

        fork
            send_frame(1'b0, 1, 128'h0);
            begin @(negedge clk); chk("crc_q_after_0", 32'(dut.crc_q), 32'h6C); end
        join

        send_frame(1'b1, 9, 128'h151);
        chk("check_good_ok", 32'(crc_ok), 1);
        chk("check_good_err", 32'(err), 0);

        fr = 128'h151 ^ (128'(1) << $urandom_range(0, 8));
        send_frame(1'b1, 9, fr);
        chk("check_flip_ok", 32'(crc_ok), 0);

        send_frame(1'b1, 5, 128'(5'($urandom)));
        chk("short_done", 32'(done), 1);
        chk("short_err", 32'(err), 1);
        chk("short_ok", 32'(crc_ok), 0);

        // Reset in the middle of generate output.
        chk_en = 1'b0;
        active = 1'b1; data = 1'b1; mode = 1'b0;
        @(negedge clk);
        active = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_valid", 32'(valid), 1);
        chk("pre_rst_bit3", 32'(crc_out), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid), 0);
        chk("mid_rst_crc_out", 32'(crc_out), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_err", 32'(err), 0);
        chk("mid_rst_crc_q", 32'(dut.crc_q), 32'hD8);
        @(negedge clk);
        reset = 1'b1;
        clear_from(cyc);
        h_ok   = 1'b0;
        h_err  = 1'b0;
        chk_en = 1'b1;
        fork
            send_frame(1'b0, 1, 128'h1);
            begin @(negedge clk); chk("crc_q_after_rst_1", 32'(dut.crc_q), 32'hA8); end
        join

        for (int t = 0; t < 40; t++) begin
            m  = 1'($urandom);
            fr = {$urandom, $urandom, $urandom, $urandom};
            if (!m) begin
                n = $urandom_range(1, 40);
            end else begin
                n  = $urandom_range(1, 30);
                cc = model_crc(16'h00D8, 16'h0044, W, n, fr);
                for (int k = 0; k < W; k++) fr[n+k] = cc[k];
                if ($urandom_range(0, 3) != 0) n = n + W;
                if ($urandom_range(0, 3) == 0) fr[$urandom_range(0, n - 1)] ^= 1'b1;
            end
            send_frame(m, n, fr);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Wider configuration: generate, then check the frame with its CRC.
        fr = 128'({$urandom, $urandom});
        c2 = model_crc(16'hFFFF, 16'h4001, 16, 64, fr);
        cap = '0;
        for (int j = 0; j < 64; j++) begin
            active2 = 1'b1; data2 = fr[j]; mode2 = 1'b0;
            @(negedge clk);
        end
        active2 = 1'b0;
        nb = 0; tmo = 0;
        while (!done2 && tmo < 100) begin
            @(negedge clk);
            tmo++;
            if (valid2) begin
                if (nb < 16) cap[nb] = crc_out2;
                nb++;
            end
        end
        chk("w16_gen_timeout", 32'(tmo < 100), 1);
        chk("w16_gen_count", 32'(nb), 16);
        chk("w16_gen_crc", 32'(cap), 32'(c2));
        for (int j = 0; j < 80; j++) begin
            active2 = 1'b1;
            data2   = (j < 64) ? fr[j] : cap[j-64];
            mode2   = (j == 0) ? 1'b1 : 1'($urandom);
            @(negedge clk);
        end
        active2 = 1'b0;
        tmo = 0;
        while (!done2 && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        chk("w16_chk_timeout", 32'(tmo < 20), 1);
        chk("w16_chk_ok", 32'(crc_ok2), 1);
        chk("w16_chk_err", 32'(err2), 0);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
